log_mac_unit: RTL and testbench

- Multiply-accumulate processing element for log-domain numbers.
- Multiplies two unpacked log numbers by adding their log exponents.
- Converts the log product to linear fixed point with a small exponential lookup.
- Adds or subtracts the result into a Kulisch-style two's-complement accumulator. Building block of the systolic log PE.

---
 rtl/log_mac_unit.sv | 126 ++++++++++++
 tb/tb_log_mac_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/log_mac_unit.sv
// Log-domain multiply-accumulate element: adds log exponents, converts the product
// to linear fixed point through a 2^x lookup and accumulates into a wide register.
module log_mac_unit #(
  parameter int M                  = 5,
  parameter int F                  = 10,
  parameter int M_OUT              = M + 1,
  parameter int LOG_TO_LINEAR_BITS = 8,
  parameter int ACC_NON_FRAC       = 11,
  parameter int ACC_FRAC           = 20,
  parameter int OVERFLOW_DETECTION = 0
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic                             inValid,
  input  logic                             aSign,
  input  logic                             aIsZero,
  input  logic                             aIsInf,
  input  logic [M+F-1:0]                   aLogExp,
  input  logic                             bSign,
  input  logic                             bIsZero,
  input  logic                             bIsInf,
  input  logic [M+F-1:0]                   bLogExp,
  input  logic [ACC_NON_FRAC+ACC_FRAC-1:0] accIn,
  input  logic                             accInIsInf,
  input  logic                             accInOverflow,
  output logic [ACC_NON_FRAC+ACC_FRAC-1:0] accOut,
  output logic                             accOutIsInf,
  output logic                             accOutOverflow
);

  localparam int EW     = M + F;
  localparam int PW     = M_OUT + F;
  localparam int ACC_W  = ACC_NON_FRAC + ACC_FRAC;
  localparam int MW     = LOG_TO_LINEAR_BITS + 1;
  localparam int IDX_W  = 5;
  localparam int BIAS   = 2 ** (M_OUT - 1);
  localparam int EXT_W  = MW + 2 ** M_OUT - 1;
  localparam int SH_LO  = BIAS + LOG_TO_LINEAR_BITS - ACC_FRAC;
  localparam bit OVF_EN = (OVERFLOW_DETECTION != 32'sd0);

  // round_half_up(2^(k/32) * 256) for the top five fraction bits; saturation is never reached
  function automatic logic [8:0] exp2_lut(input logic [4:0] idx);
    case (idx)
      5'd0:  exp2_lut = 9'd256;  5'd1:  exp2_lut = 9'd262;
      5'd2:  exp2_lut = 9'd267;  5'd3:  exp2_lut = 9'd273;
      5'd4:  exp2_lut = 9'd279;  5'd5:  exp2_lut = 9'd285;
      5'd6:  exp2_lut = 9'd292;  5'd7:  exp2_lut = 9'd298;
      5'd8:  exp2_lut = 9'd304;  5'd9:  exp2_lut = 9'd311;
      5'd10: exp2_lut = 9'd318;  5'd11: exp2_lut = 9'd325;
      5'd12: exp2_lut = 9'd332;  5'd13: exp2_lut = 9'd339;
      5'd14: exp2_lut = 9'd347;  5'd15: exp2_lut = 9'd354;
      5'd16: exp2_lut = 9'd362;  5'd17: exp2_lut = 9'd370;
      5'd18: exp2_lut = 9'd378;  5'd19: exp2_lut = 9'd386;
      5'd20: exp2_lut = 9'd395;  5'd21: exp2_lut = 9'd403;
      5'd22: exp2_lut = 9'd412;  5'd23: exp2_lut = 9'd421;
      5'd24: exp2_lut = 9'd431;  5'd25: exp2_lut = 9'd440;
      5'd26: exp2_lut = 9'd450;  5'd27: exp2_lut = 9'd459;
      5'd28: exp2_lut = 9'd470;  5'd29: exp2_lut = 9'd480;
      5'd30: exp2_lut = 9'd490;  5'd31: exp2_lut = 9'd501;
      default: exp2_lut = 9'd256;
    endcase
  endfunction

  logic [PW-1:0]    prod_log_s;
  logic [M_OUT-1:0] prod_exp_s;
  logic [M_OUT-1:0] shift_s;
  logic [IDX_W-1:0] lut_idx_s;
  logic [MW-1:0]    mant_s;
  logic [EXT_W-1:0] ext_s;
  logic [ACC_W-1:0] mag_s;
  logic [ACC_W-1:0] sum_s;
  logic             prod_sign_s;
  logic             out_of_range_s;
  logic             add_ovf_s;
  logic             unused_s;
  logic [ACC_W-1:0] acc_nxt_s;
  logic             inf_nxt_s;
  logic             ovf_nxt_s;

  assign prod_log_s  = {{(PW-EW){aLogExp[EW-1]}}, aLogExp} + {{(PW-EW){bLogExp[EW-1]}}, bLogExp};
  assign prod_exp_s  = prod_log_s[PW-1:F];
  assign lut_idx_s   = prod_log_s[F-1 -: IDX_W];
  assign mant_s      = exp2_lut(lut_idx_s);
  assign prod_sign_s = aSign ^ bSign;

  // Biased exponent makes the shift non-negative; the grid LSB then sits at bit SH_LO.
  assign shift_s        = {~prod_exp_s[M_OUT-1], prod_exp_s[M_OUT-2:0]};
  assign ext_s          = {{(EXT_W-MW){1'b0}}, mant_s} << shift_s;
  assign mag_s          = ext_s[SH_LO +: ACC_W];
  assign out_of_range_s = |ext_s[EXT_W-1:SH_LO+ACC_W-1];
  // Fraction bits finer than the lookup index and below the grid LSB are dropped.
  assign unused_s       = ^{prod_log_s[F-IDX_W-1:0], ext_s[SH_LO-1:0]};

  assign sum_s     = prod_sign_s ? (accIn - mag_s) : (accIn + mag_s);
  assign add_ovf_s = (sum_s[ACC_W-1] != accIn[ACC_W-1]) &&
                     ((accIn[ACC_W-1] == mag_s[ACC_W-1]) != prod_sign_s);

  // Next accumulator value and sticky flags
  always_comb begin
    acc_nxt_s = accIn;
    inf_nxt_s = accInIsInf;
    ovf_nxt_s = accInOverflow;
    if (inValid && (aIsInf || bIsInf)) begin
      inf_nxt_s = 1'b1;
    end else if (inValid && !aIsZero && !bIsZero) begin
      acc_nxt_s = sum_s;
      ovf_nxt_s = accInOverflow | add_ovf_s | out_of_range_s;
    end else begin
      acc_nxt_s = accIn;
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      accOut         <= '0;
      accOutIsInf    <= 1'b0;
      accOutOverflow <= 1'b0;
    end else begin
      accOut         <= acc_nxt_s;
      accOutIsInf    <= inf_nxt_s;
      accOutOverflow <= OVF_EN & ovf_nxt_s;
    end
  end

endmodule

// File: tb/tb_log_mac_unit.sv
// Bench for log_mac_unit: directed literal cases plus random stimulus against an
// arithmetic reference model, for both overflow-detection settings.
module tb_log_mac_unit;

  localparam int  W   = 31;
  localparam longint LIM = 64'sd1 << 30;

  typedef struct packed {
    logic [W-1:0] acc;
    logic         inf;
    logic         ovf;
  } res_t;

  logic clock, resetn;
  logic in_valid, a_sign, a_zero, a_inf, b_sign, b_zero, b_inf;
  logic [14:0] a_log, b_log;
  logic [W-1:0] acc_in;
  logic acc_in_inf, acc_in_ovf;
  logic [W-1:0] acc0, acc1;
  logic inf0, inf1, ovf0, ovf1;
  res_t exp0, exp1;
  int checks = 0;
  int errors = 0;

  log_mac_unit #(.OVERFLOW_DETECTION(0)) dut0 (
    .clock(clock), .resetn(resetn), .inValid(in_valid),
    .aSign(a_sign), .aIsZero(a_zero), .aIsInf(a_inf), .aLogExp(a_log),
    .bSign(b_sign), .bIsZero(b_zero), .bIsInf(b_inf), .bLogExp(b_log),
    .accIn(acc_in), .accInIsInf(acc_in_inf), .accInOverflow(acc_in_ovf),
    .accOut(acc0), .accOutIsInf(inf0), .accOutOverflow(ovf0));

  log_mac_unit #(.OVERFLOW_DETECTION(1)) dut1 (
    .clock(clock), .resetn(resetn), .inValid(in_valid),
    .aSign(a_sign), .aIsZero(a_zero), .aIsInf(a_inf), .aLogExp(a_log),
    .bSign(b_sign), .bIsZero(b_zero), .bIsInf(b_inf), .bLogExp(b_log),
    .accIn(acc_in), .accInIsInf(acc_in_inf), .accInOverflow(acc_in_ovf),
    .accOut(acc1), .accOutIsInf(inf1), .accOutOverflow(ovf1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: real-valued product, exact integer accumulation, then wrap.
  function automatic res_t model(input bit od);
    res_t o;
    int p, e, f, fq, mant, s;
    longint ai, mag, r;
    real v;
    o.acc = acc_in;
    o.inf = acc_in_inf;
    o.ovf = acc_in_ovf;
    if (in_valid) begin
      if (a_inf || b_inf) begin
        o.inf = 1'b1;
      end else if (!a_zero && !b_zero) begin
        p    = int'(signed'(a_log)) + int'(signed'(b_log));
        f    = p & 1023;
        e    = (p - f) / 1024;
        fq   = (f / 32) * 32;
        v    = $pow(2.0, real'(fq) / 1024.0) * 256.0;
        mant = int'($floor(v + 0.5));
        if (mant > 511) mant = 511;
        s    = e + 12;
        if (s >= 0) mag = longint'(mant) << s;
        else        mag = longint'(mant >> (-s));
        ai   = longint'(signed'(acc_in));
        r    = (a_sign ^ b_sign) ? ai - mag : ai + mag;
        o.acc = r[W-1:0];
        if (mag >= LIM || r < -LIM || r >= LIM) o.ovf = 1'b1;
      end
    end
    if (!od) o.ovf = 1'b0;
    return o;
  endfunction

  // Expected register contents, updated on the same edges as the DUT
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      exp0 <= '0;
      exp1 <= '0;
    end else begin
      exp0 <= model(1'b0);
      exp1 <= model(1'b1);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    chk("acc_od0", 64'(acc0), 64'(exp0.acc));
    chk("inf_od0", 64'(inf0), 64'(exp0.inf));
    chk("ovf_od0", 64'(ovf0), 64'(exp0.ovf));
    chk("acc_od1", 64'(acc1), 64'(exp1.acc));
    chk("inf_od1", 64'(inf1), 64'(exp1.inf));
    chk("ovf_od1", 64'(ovf1), 64'(exp1.ovf));
  end

  task automatic apply(input bit vld, input bit as, input bit az, input bit ainf, input logic [14:0] al,
                       input bit bs, input bit bz, input bit binf, input logic [14:0] bl,
                       input logic [W-1:0] ai, input bit aiinf, input bit aiovf);
    in_valid = vld; a_sign = as; a_zero = az; a_inf = ainf; a_log = al;
    b_sign = bs; b_zero = bz; b_inf = binf; b_log = bl;
    acc_in = ai; acc_in_inf = aiinf; acc_in_ovf = aiovf;
  endtask

  task automatic step;
    @(negedge clock);
    #1;
  endtask

  task automatic lit(input string name, input logic [W-1:0] acc, input bit inf, input bit o0, input bit o1);
    chk({name, "_acc0"}, 64'(acc0), 64'(acc));
    chk({name, "_acc1"}, 64'(acc1), 64'(acc));
    chk({name, "_inf"}, 64'(inf1), 64'(inf));
    chk({name, "_ovf0"}, 64'(ovf0), 64'(o0));
    chk({name, "_ovf1"}, 64'(ovf1), 64'(o1));
    chk({name, "_model"}, 64'(exp1.acc), 64'(acc));
  endtask

  initial begin
    resetn = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0, 15'd0, 31'd0, 1'b0, 1'b0);
    #3;
    lit("reset_init", 31'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    #1;

    apply(1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0, 15'd0, 31'd0, 1'b0, 1'b0);
    step(); lit("unit", 31'h0010_0000, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 15'd512, 1'b0, 1'b0, 1'b0, 15'd0, 31'd0, 1'b0, 1'b0);
    step(); lit("sqrt2", 31'h0016_A000, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 15'd512, 1'b0, 1'b0, 1'b0, 15'd0, 31'h0010_0000, 1'b0, 1'b0);
    step(); lit("sqrt2_neg", 31'h7FF9_6000, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 15'd512, 1'b0, 1'b0, 1'b0, 15'd512, 31'd0, 1'b0, 1'b0);
    step(); lit("carry", 31'h0020_0000, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 15'd512, 1'b0, 1'b0, 1'b0, 15'd0, 31'h0012_3456, 1'b0, 1'b1);
    step(); lit("zero", 31'h0012_3456, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b1, 15'd0, 31'h0000_0055, 1'b0, 1'b0);
    step(); lit("inf", 31'h0000_0055, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0, 15'd0, 31'h0000_0055, 1'b1, 1'b0);
    step(); lit("inf_fb", 31'h0010_0055, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 15'd10240, 1'b0, 1'b0, 1'b0, 15'd0, 31'd0, 1'b0, 1'b0);
    step(); lit("oor", 31'h4000_0000, 1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0, 15'd0, 31'h3FFF_FFFF, 1'b0, 1'b0);
    step(); lit("add_ovf", 31'h400F_FFFF, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 15'd512, 1'b0, 1'b0, 1'b0, 15'd0, 31'h3ABC_DEF1, 1'b1, 1'b1);
    step(); lit("idle", 31'h3ABC_DEF1, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset between edges, then restart from accIn
    apply(1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0, 15'd0, 31'h0030_0000, 1'b1, 1'b1);
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    lit("reset_mid", 31'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    step(); lit("post_reset", 31'h0040_0000, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic [14:0] al, bl;
      logic [W-1:0] ai;
      if ($urandom_range(0, 1) == 0) begin
        al = 15'($urandom);
        bl = 15'($urandom);
      end else begin
        al = 15'($urandom_range(0, 8191)) - 15'd4096;
        bl = 15'($urandom_range(0, 8191)) - 15'd4096;
      end
      ai = ($urandom_range(0, 2) == 0) ? exp1.acc : W'($urandom);
      apply($urandom_range(0, 9) != 0, 1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0, al,
            1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0, bl,
            ai, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      @(negedge clock);
      #1;
    end

    @(negedge clock);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
